// File: rtl/hls_bb_pkg.sv
// Shared types and constants for the hls_bb_arbiter slice.
// Pure declarations: no latency and no backpressure of its own.
package hls_bb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int XW_DEF       = 5;
  localparam int RES_FLAG_BIT = XW_DEF;
  localparam int CNT_W        = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first asserted req at or after ptr, wrapping.
// Purely combinational (zero latency); applies no backpressure itself.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  int            pos;
  logic [IW-1:0] pos_w;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = 0;
    pos_w   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      pos_w = IW'(pos);
      if (!gnt_vld && req[pos_w]) begin
        gnt[pos_w] = 1'b1;
        gnt_idx    = pos_w;
        gnt_vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hls_bb_arbiter.sv
// Shares one add/flag black box among N requesters; accept->rsp_valid is 3 cycles when idle.
// Requests wait in IDLE for a grant; a response holds until its rsp_ready, stalling new grants.
module hls_bb_arbiter
  import hls_bb_pkg::*;
#(
  parameter int N       = 4,
  parameter int XW      = XW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N-1:0]     req_cmd,
  input  logic [N*XW-1:0]  req_x,
  input  logic [N-1:0]     req_y,
  output logic [N-1:0]     rsp_valid,
  input  logic [N-1:0]     rsp_ready,
  output logic [XW-1:0]    rsp_data,
  output logic             rsp_flag,
  output logic             rsp_timeout,
  output logic             bb_ap_start,
  output logic             bb_ap_ce,
  output logic             bb_ap_continue,
  input  logic             bb_ap_ready,
  input  logic             bb_ap_done,
  output logic             bb_cmd,
  output logic [XW-1:0]    bb_x,
  output logic             bb_y,
  input  logic [XW:0]      bb_res,
  output logic [CNT_W-1:0] stray_done_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int IW       = $clog2(N);
  localparam int WDW      = $clog2(TIMEOUT);
  localparam int FLAG_BIT = RES_FLAG_BIT + (XW - XW_DEF);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, gidx_q, ptr_nxt;
  logic [WDW-1:0] wd_q;

  logic [N-1:0]   arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_vld;

  logic           accept, done_hit, wd_fire;
  logic           sel_cmd, sel_y;
  logic [XW-1:0]  sel_x;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign bb_ap_ce       = 1'b1;
  assign bb_ap_continue = 1'b1;
  assign ptr_nxt        = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;
  assign req_ready      = accept ? arb_gnt : '0;

  always_comb begin
    sel_cmd = 1'b0;
    sel_y   = 1'b0;
    sel_x   = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_cmd = req_cmd[i];
        sel_y   = req_y[i];
        sel_x   = req_x[i*XW +: XW];
      end
    end
  end

  // Accept is masked during reset so nothing is handed over that the registers would drop.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_hit = 1'b0;
    wd_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld && !ap_rst) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wd_q == WD_LAST) begin
          wd_fire = 1'b1;
          state_d = RESP;
        end else if (bb_ap_start && bb_ap_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bb_ap_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (wd_q == WD_LAST) begin
          wd_fire = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[gidx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gidx_q] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gidx_q         <= '0;
      wd_q           <= '0;
      bb_ap_start    <= 1'b0;
      bb_cmd         <= 1'b0;
      bb_x           <= '0;
      bb_y           <= 1'b0;
      rsp_data       <= '0;
      rsp_flag       <= 1'b0;
      rsp_timeout    <= 1'b0;
      stray_done_cnt <= '0;
      timeout_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      // Start is high exactly while in ISSUE, so it drops on WAIT or watchdog exit.
      bb_ap_start <= (state_d == ISSUE);

      if (accept) begin
        ptr_q  <= ptr_nxt;
        gidx_q <= arb_idx;
        bb_cmd <= sel_cmd;
        bb_x   <= sel_x;
        bb_y   <= sel_y;
        wd_q   <= '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
        wd_q <= wd_q + 1'b1;
      end

      if (done_hit) begin
        rsp_data    <= bb_res[XW-1:0];
        rsp_flag    <= bb_res[FLAG_BIT];
        rsp_timeout <= 1'b0;
      end else if (wd_fire) begin
        rsp_data    <= '0;
        rsp_flag    <= 1'b0;
        rsp_timeout <= 1'b1;
        timeout_cnt <= sat_inc(timeout_cnt);
      end

      if (bb_ap_done && state_q != WAIT) stray_done_cnt <= sat_inc(stray_done_cnt);
    end
  end

endmodule

// File: tb/tb_hls_bb_arbiter.sv
// Directed bench for hls_bb_arbiter with a behavioural black box and a response scoreboard.
// Inputs change on the falling edge; handshakes are sampled 1ns later, before the rising edge.
module tb_hls_bb_arbiter;

  localparam int N       = 4;
  localparam int XW      = 5;
  localparam int TIMEOUT = 16;

  logic            ap_clk = 1'b0;
  logic            ap_rst;
  logic [N-1:0]    req_valid, req_ready, req_cmd, req_y;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]    rsp_valid, rsp_ready;
  logic [XW-1:0]   rsp_data;
  logic            rsp_flag, rsp_timeout;
  logic            bb_ap_start, bb_ap_ce, bb_ap_continue, bb_ap_ready, bb_ap_done;
  logic            bb_cmd, bb_y;
  logic [XW-1:0]   bb_x;
  logic [XW:0]     bb_res;
  logic [7:0]      stray_done_cnt, timeout_cnt;

  logic            done_en, rdy_en, inj_done;
  logic            mdl_done = 1'b0;
  logic [XW:0]     mdl_res  = '0;

  typedef struct {
    int idx;
    int data;
    int flag;
    int tmo;
  } exp_t;

  exp_t sb[$];
  int   gnt_exp[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  always #5 ap_clk = ~ap_clk;

  hls_bb_arbiter #(.N(N), .XW(XW), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_x          (req_x),
    .req_y          (req_y),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_flag       (rsp_flag),
    .rsp_timeout    (rsp_timeout),
    .bb_ap_start    (bb_ap_start),
    .bb_ap_ce       (bb_ap_ce),
    .bb_ap_continue (bb_ap_continue),
    .bb_ap_ready    (bb_ap_ready),
    .bb_ap_done     (bb_ap_done),
    .bb_cmd         (bb_cmd),
    .bb_x           (bb_x),
    .bb_y           (bb_y),
    .bb_res         (bb_res),
    .stray_done_cnt (stray_done_cnt),
    .timeout_cnt    (timeout_cnt)
  );

  // Black box: done one cycle after the start/ready handshake; res = {!cmd, cmd ? x+y : 0}.
  assign bb_ap_ready = rdy_en;
  assign bb_ap_done  = mdl_done | inj_done;
  assign bb_res      = mdl_res;

  always @(posedge ap_clk) begin
    mdl_done <= done_en && bb_ap_start && bb_ap_ready;
    if (bb_ap_start && bb_ap_ready)
      mdl_res <= bb_cmd ? {1'b0, bb_x + XW'(bb_y)} : {1'b1, {XW{1'b0}}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic c, input logic [XW-1:0] x, input logic y);
    req_cmd[i]         = c;
    req_x[i*XW +: XW]  = x;
    req_y[i]           = y;
  endtask

  // Samples the handshakes the DUT will commit at the next rising edge, then advances a cycle.
  task automatic cyc();
    int            g;
    exp_t          e;
    logic [XW-1:0] sum;
    logic [N-1:0]  m;
    #1;
    if (req_ready != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      chk("req_ready_onehot", $countones(req_ready), 1);
      if (gnt_exp.size() > 0) chk("grant_order", g, gnt_exp.pop_front());
      sum   = req_x[g*XW +: XW] + XW'(req_y[g]);
      e.idx = g;
      if (done_en) begin
        e.data = req_cmd[g] ? int'(sum) : 0;
        e.flag = req_cmd[g] ? 0 : 1;
        e.tmo  = 0;
      end else begin
        e.data = 0;
        e.flag = 0;
        e.tmo  = 1;
      end
      sb.push_back(e);
      acc_cyc.push_back(cyc_n);
    end
    if ((rsp_valid & rsp_ready) != '0) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{0, 0, 0, 0};
      m = '0;
      m[e.idx] = 1'b1;
      chk("rsp_route", rsp_valid, m);
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_flag", rsp_flag, e.flag);
      chk("rsp_timeout", rsp_timeout, e.tmo);
    end
    @(negedge ap_clk);
    cyc_n++;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_rsp", rsp_valid != '0, 1);
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_req_ready"}, req_ready, 0);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_bb_ap_start"}, bb_ap_start, 0);
    chk({p, "_bb_ap_ce"}, bb_ap_ce, 1);
    chk({p, "_bb_ap_continue"}, bb_ap_continue, 1);
    chk({p, "_stray_cnt"}, stray_done_cnt, 0);
    chk({p, "_timeout_cnt"}, timeout_cnt, 0);
    chk({p, "_rsp_data"}, rsp_data, 0);
    chk({p, "_rsp_timeout"}, rsp_timeout, 0);
    chk({p, "_bb_x"}, bb_x, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int a0;
    ap_rst    = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = '1;
    done_en   = 1'b1;
    rdy_en    = 1'b1;
    inj_done  = 1'b0;
    @(negedge ap_clk);
    cyc();
    cyc();
    reset_checks("rst");
    ap_rst = 1'b0;

    // Single request, nominal latency.
    set_req(0, 1'b1, 5'd7, 1'b1);
    req_valid = 4'b0001;
    #1 chk("t1_req_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    chk("t1_start_c1", bb_ap_start, 1);
    chk("t1_bb_x", bb_x, 7);
    chk("t1_bb_cmd", bb_cmd, 1);
    chk("t1_bb_y", bb_y, 1);
    chk("t1_no_rsp_c1", rsp_valid, 0);
    cyc();
    chk("t1_start_c2", bb_ap_start, 0);
    chk("t1_no_rsp_c2", rsp_valid, 0);
    cyc();
    chk("t1_rsp_valid_c3", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 8);
    chk("t1_rsp_flag", rsp_flag, 0);
    chk("t1_rsp_timeout", rsp_timeout, 0);
    cyc();
    chk("t1_rsp_done", rsp_valid, 0);

    // cmd=0 from requester 2.
    set_req(2, 1'b0, 5'd3, 1'b0);
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    wait_rsp(n);
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    chk("t2_rsp_flag", rsp_flag, 1);
    chk("t2_rsp_data", rsp_data, 0);
    cyc();

    // Reset returns the pointer to 0, then all four requesters contend.
    ap_rst = 1'b1;
    cyc();
    reset_checks("t3rst");
    ap_rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, XW'(i), i[0]);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    gnt_exp.push_back(2);
    gnt_exp.push_back(3);
    gnt_exp.push_back(0);
    req_valid = 4'b1111;
    a0 = acc_cyc.size();
    n  = 0;
    while (acc_cyc.size() < a0 + 5 && n < 60) begin
      cyc();
      n++;
    end
    req_valid = '0;
    chk("t3_grant_count", acc_cyc.size() - a0, 5);
    for (int k = 1; k < 5; k++)
      chk("t3_grant_spacing", acc_cyc[a0+k] - acc_cyc[a0+k-1], 4);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    chk("t3_drain", sb.size(), 0);
    chk("t3_grants_used", gnt_exp.size(), 0);

    // Response backpressure on requester 1 while requester 0 waits.
    set_req(1, 1'b1, 5'd9, 1'b1);
    set_req(0, 1'b1, 5'd4, 1'b0);
    rsp_ready = 4'b1101;
    req_valid = 4'b0011;
    #1 chk("t4_first_grant", req_ready, 4'b0010);
    cyc();
    wait_rsp(n);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_hold_valid", rsp_valid, 4'b0010);
      chk("t4_hold_data", rsp_data, 10);
      chk("t4_no_grant", req_ready, 0);
      cyc();
    end
    rsp_ready = 4'b1111;
    #1 chk("t4_no_grant_on_accept", req_ready, 0);
    cyc();
    #1 chk("t4_next_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    wait_rsp(n);
    cyc();
    chk("t4_drain", sb.size(), 0);

    // Watchdog: ready held low for 3 cycles, done never arrives.
    done_en = 1'b0;
    rdy_en  = 1'b0;
    set_req(3, 1'b1, 5'd5, 1'b0);
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_start_held", bb_ap_start, 1);
      chk("t5_bb_x_stable", bb_x, 5);
      cyc();
    end
    rdy_en = 1'b1;
    wait_rsp(n);
    chk("t5_latency", cyc_n - acc_cyc[acc_cyc.size()-1], TIMEOUT + 1);
    chk("t5_rsp_valid", rsp_valid, 4'b1000);
    chk("t5_timeout_flag", rsp_timeout, 1);
    chk("t5_timeout_cnt", timeout_cnt, 1);
    chk("t5_start_dropped", bb_ap_start, 0);
    cyc();
    chk("t5_stray_before", stray_done_cnt, 0);
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    chk("t5_stray_after", stray_done_cnt, 1);
    chk("t5_no_rsp_from_stray", rsp_valid, 0);
    chk("t5_timeout_cnt_kept", timeout_cnt, 1);

    // Reset while waiting for done aborts the request.
    set_req(1, 1'b1, 5'd2, 1'b0);
    req_valid = 4'b0010;
    cyc();
    req_valid = '0;
    cyc();
    chk("t6_wait_start_low", bb_ap_start, 0);
    chk("t6_wait_no_rsp", rsp_valid, 0);
    ap_rst    = 1'b1;
    req_valid = 4'b1010;
    cyc();
    sb.delete();
    reset_checks("t6rst");
    ap_rst  = 1'b0;
    done_en = 1'b1;
    #1 chk("t6_ptr_zero_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    wait_rsp(n);
    cyc();
    chk("end_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_bb_arbiter.md
Name: hls_bb_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one hls_black_box add/flag datapath between N requesters.
- Accepts operand requests (cmd, x, y) on per-requester valid/ready channels and drives the block-level ap_start/ap_ready/ap_done handshake.
- Captures the 6-bit result and returns it on the granted requester's response channel.
- Adds a timeout watchdog and a stray-done counter for robustness.

Parameters:
- N, 4: number of requesters (2..8).
- XW, 5: width of the x operand and of the result data field.
- TIMEOUT, 16: cycles allowed from ISSUE entry until bb_ap_done before an error response (>=4).

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  one-hot accept pulse
- req_cmd  in  N  cmd bit per requester
- req_x  in  N*XW  x operand, requester i at [i*XW +: XW]
- req_y  in  N  y bit per requester
- rsp_valid  out  N  one-hot response valid
- rsp_ready  in  N  per-requester response accept
- rsp_data  out  XW  result sum (shared bus)
- rsp_flag  out  1  black-box res[XW] (cmd==0 indication)
- rsp_timeout  out  1  response produced by watchdog
- bb_ap_start  out  1  to black box ap_start
- bb_ap_ce  out  1  tied 1
- bb_ap_continue  out  1  tied 1
- bb_ap_ready  in  1  from black box
- bb_ap_done  in  1  from black box
- bb_cmd  out  1  registered operand
- bb_x  out  XW  registered operand
- bb_y  out  1  registered operand
- bb_res  in  XW+1  black-box result
- stray_done_cnt  out  8  count of bb_ap_done seen outside WAIT, saturating
- timeout_cnt  out  8  count of watchdog responses, saturating

Behaviour:
- Reset values: state IDLE, rr pointer 0, all outputs 0 except bb_ap_ce=1 and bb_ap_continue=1; counters 0.
- Reset mid-operation aborts everything. No response is produced for the in-flight request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first index at or after the pointer (wrapping) with req_valid high.
  - req_ready[g]=1 combinationally for that cycle only.
  - Register req_cmd[g], req_x[g], req_y[g] into bb_*, store g.
  - Pointer <= (g+1) mod N; go to ISSUE.
  - No valid request: stay in IDLE, pointer unchanged.
- ISSUE:
  - bb_ap_start=1 (registered).
  - Leave for WAIT after a cycle in which bb_ap_start and bb_ap_ready are both high. Start is held while bb_ap_ready is low.
  - bb_ap_start drops in the cycle WAIT is entered.
- WAIT: on bb_ap_done=1, capture bb_res into rsp_data/rsp_flag, set rsp_timeout=0, go to RESP.
- Watchdog:
  - A counter clears on ISSUE entry and increments every cycle in ISSUE/WAIT.
  - At TIMEOUT-1 without done: go to RESP with rsp_data=0, rsp_flag=0, rsp_timeout=1; drop bb_ap_start; increment timeout_cnt.
  - If done arrives in that same cycle, done wins (normal response).
- RESP:
  - rsp_valid[g]=1; data held stable until rsp_ready[g] is high.
  - Then go to IDLE; no new grant in the same cycle.
  - Other rsp_ready bits are ignored.
- bb_ap_done outside WAIT (e.g. late done after a timeout) is ignored except for incrementing stray_done_cnt.
- Both counters saturate at 255.
- Nominal latency with an idle black box:
  - accept at cycle 0
  - start at cycle 1
  - done at cycle 2
  - rsp_valid at cycle 3
  - A back-to-back throughput of one op per 4 cycles plus response stall.
- Fairness: a requester holding req_valid is granted within N grants.
- Operands are 1-cycle registered; bb_x/bb_y/bb_cmd are stable for the whole ISSUE/WAIT.

Decomposition:
- Package hls_bb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - XW default
  - result field constants (RES_FLAG_BIT = XW)
  - counter width 8
- Sub-module rr_arbiter (N req bits, pointer in, one-hot grant + index out; pure combinational priority rotate).
- FSM, watchdog and counters stay in the top.

Test Plan:
- Single request: req0 cmd=1 x=7 y=1. Required: bb_x=7, start cycle 1, rsp_valid[0] cycle 3 with rsp_data=8, flag=0, timeout=0.
- cmd=0 request from req2 (x=3, y=0). Required: rsp_flag=1, rsp_valid[2] only, rsp_data=0 from the black box.
- All four requesters valid continuously with x=i. Required: grants 0,1,2,3,0; responses routed to matching index with data i+y.
- Response backpressure: hold rsp_ready[1]=0 for 5 cycles. Required: rsp_valid/rsp_data stable, no new req_ready pulse until accepted.
- Black-box model never asserts done. Required: response at TIMEOUT cycles after ISSUE entry with timeout=1, timeout_cnt=1. A late done then gives stray_done_cnt=1.
- Assert ap_rst during WAIT. Required: next cycle state IDLE, all rsp_valid/req_ready/bb_ap_start 0, counters 0, pointer 0.
